l1_noc_out_arbiter: RTL and testbench



---
 rtl/l1_noc_out_arbiter.sv | 128 ++++++++++++
 tb/tb_l1_noc_out_arbiter.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/l1_noc_out_arbiter.sv
// Two-requester round-robin arbiter that feeds the core's NoC packetizer from the
// I-cache (requester 0) and D-cache (requester 1) interfaces through one output register.
module l1_noc_out_arbiter #(
    parameter int MSG_BITS          = 4,
    parameter int ADDRESS_BITS      = 32,
    parameter int DATA_WIDTH        = 32,
    parameter int CACHE_OFFSET_BITS = 2,
    parameter int ID_BITS           = 2,
    parameter int CNT_BITS          = 16,
    localparam int CACHE_WIDTH      = DATA_WIDTH << CACHE_OFFSET_BITS
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [MSG_BITS-1:0]     req0_msg_in,
    input  logic [ADDRESS_BITS-1:0] req0_address_in,
    input  logic [CACHE_WIDTH-1:0]  req0_data_in,
    input  logic [ID_BITS-1:0]      req0_dest_id,
    output logic                    req0_busy,
    input  logic [MSG_BITS-1:0]     req1_msg_in,
    input  logic [ADDRESS_BITS-1:0] req1_address_in,
    input  logic [CACHE_WIDTH-1:0]  req1_data_in,
    input  logic [ID_BITS-1:0]      req1_dest_id,
    output logic                    req1_busy,
    output logic [MSG_BITS-1:0]     pkt_msg_out,
    output logic [ADDRESS_BITS-1:0] pkt_address_out,
    output logic [CACHE_WIDTH-1:0]  pkt_data_out,
    output logic [ID_BITS-1:0]      pkt_dest_id,
    input  logic                    packetizer_busy,
    output logic                    last_grant,
    output logic [CNT_BITS-1:0]     req0_sent,
    output logic [CNT_BITS-1:0]     req1_sent
);

    localparam logic [CNT_BITS-1:0] CNT_ONE = {{(CNT_BITS-1){1'b0}}, 1'b1};

    logic out_valid_r;
    logic rr_ptr_r;
    logic valid0_s;
    logic valid1_s;
    logic consume_s;
    logic can_load_s;
    logic grant_s;
    logic grant_valid_s;
    logic accept0_s;
    logic accept1_s;

    assign valid0_s   = (req0_msg_in != {MSG_BITS{1'b0}});
    assign valid1_s   = (req1_msg_in != {MSG_BITS{1'b0}});
    assign consume_s  = out_valid_r & ~packetizer_busy;
    assign can_load_s = ~out_valid_r | consume_s;

    // Round-robin grant: rr_ptr only matters when both requesters are valid
    always_comb begin
        grant_s       = 1'b0;
        grant_valid_s = 1'b0;
        if (valid0_s && valid1_s) begin
            grant_s       = rr_ptr_r;
            grant_valid_s = 1'b1;
        end else if (valid1_s) begin
            grant_s       = 1'b1;
            grant_valid_s = 1'b1;
        end else if (valid0_s) begin
            grant_s       = 1'b0;
            grant_valid_s = 1'b1;
        end else begin
            grant_s       = 1'b0;
            grant_valid_s = 1'b0;
        end
    end

    // Gating with reset keeps both requesters held while the block is in reset
    assign accept0_s = reset & can_load_s & grant_valid_s & ~grant_s & valid0_s;
    assign accept1_s = reset & can_load_s & grant_valid_s &  grant_s & valid1_s;

    assign req0_busy = ~accept0_s;
    assign req1_busy = ~accept1_s;

    // Output register, tie pointer and last-grant tracking
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            out_valid_r     <= 1'b0;
            rr_ptr_r        <= 1'b0;
            last_grant      <= 1'b0;
            pkt_msg_out     <= {MSG_BITS{1'b0}};
            pkt_address_out <= {ADDRESS_BITS{1'b0}};
            pkt_data_out    <= {CACHE_WIDTH{1'b0}};
            pkt_dest_id     <= {ID_BITS{1'b0}};
        end else if (accept0_s) begin
            out_valid_r     <= 1'b1;
            rr_ptr_r        <= 1'b1;
            last_grant      <= 1'b0;
            pkt_msg_out     <= req0_msg_in;
            pkt_address_out <= req0_address_in;
            pkt_data_out    <= req0_data_in;
            pkt_dest_id     <= req0_dest_id;
        end else if (accept1_s) begin
            out_valid_r     <= 1'b1;
            rr_ptr_r        <= 1'b0;
            last_grant      <= 1'b1;
            pkt_msg_out     <= req1_msg_in;
            pkt_address_out <= req1_address_in;
            pkt_data_out    <= req1_data_in;
            pkt_dest_id     <= req1_dest_id;
        end else if (consume_s) begin
            out_valid_r     <= 1'b0;
            pkt_msg_out     <= {MSG_BITS{1'b0}};
            pkt_address_out <= {ADDRESS_BITS{1'b0}};
            pkt_data_out    <= {CACHE_WIDTH{1'b0}};
            pkt_dest_id     <= {ID_BITS{1'b0}};
        end
    end

    // Per-requester accepted-message counters, wrapping naturally
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            req0_sent <= {CNT_BITS{1'b0}};
            req1_sent <= {CNT_BITS{1'b0}};
        end else begin
            if (accept0_s) begin
                req0_sent <= req0_sent + CNT_ONE;
            end
            if (accept1_s) begin
                req1_sent <= req1_sent + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_l1_noc_out_arbiter.sv
// Directed bench for l1_noc_out_arbiter: a vector table for single-cycle behaviour plus
// hand-written sequences for reset, contention and counter wrap.
module tb_l1_noc_out_arbiter;

    logic         clock;
    logic         reset;
    logic [3:0]   r0_msg, r1_msg;
    logic [31:0]  r0_addr, r1_addr;
    logic [127:0] r0_data, r1_data;
    logic [1:0]   r0_dest, r1_dest;
    logic         pkt_busy;

    logic         busy0, busy1, lg;
    logic [3:0]   p_msg;
    logic [31:0]  p_addr;
    logic [127:0] p_data;
    logic [1:0]   p_dest;
    logic [15:0]  sent0, sent1;

    logic         w_busy0, w_busy1, w_lg;
    logic [3:0]   w_msg;
    logic [31:0]  w_addr;
    logic [127:0] w_data;
    logic [1:0]   w_dest;
    logic [3:0]   w_sent0, w_sent1;

    int n_cmp = 0;
    int n_err = 0;

    l1_noc_out_arbiter dut (
        .clock(clock), .reset(reset),
        .req0_msg_in(r0_msg), .req0_address_in(r0_addr), .req0_data_in(r0_data),
        .req0_dest_id(r0_dest), .req0_busy(busy0),
        .req1_msg_in(r1_msg), .req1_address_in(r1_addr), .req1_data_in(r1_data),
        .req1_dest_id(r1_dest), .req1_busy(busy1),
        .pkt_msg_out(p_msg), .pkt_address_out(p_addr), .pkt_data_out(p_data),
        .pkt_dest_id(p_dest), .packetizer_busy(pkt_busy), .last_grant(lg),
        .req0_sent(sent0), .req1_sent(sent1)
    );

    l1_noc_out_arbiter #(.CNT_BITS(4)) dut_w (
        .clock(clock), .reset(reset),
        .req0_msg_in(r0_msg), .req0_address_in(r0_addr), .req0_data_in(r0_data),
        .req0_dest_id(r0_dest), .req0_busy(w_busy0),
        .req1_msg_in(r1_msg), .req1_address_in(r1_addr), .req1_data_in(r1_data),
        .req1_dest_id(r1_dest), .req1_busy(w_busy1),
        .pkt_msg_out(w_msg), .pkt_address_out(w_addr), .pkt_data_out(w_data),
        .pkt_dest_id(w_dest), .packetizer_busy(pkt_busy), .last_grant(w_lg),
        .req0_sent(w_sent0), .req1_sent(w_sent1)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    typedef struct {
        logic         pb;
        logic [3:0]   m0;
        logic [31:0]  a0;
        logic [3:0]   m1;
        logic [31:0]  a1;
        logic [1:0]   busy;   // {busy1, busy0} before the edge
        logic [3:0]   msg;    // registered outputs after the edge
        logic [31:0]  addr;
        logic [127:0] data;
        logic [1:0]   dest;
        logic         lg;
    } vec_t;

    vec_t vt[16];

    // Cache line attached to an address; the PutM address carries its fixed test pattern
    function automatic logic [127:0] line(input logic [31:0] a);
        if (a == 32'h0002_0000) return 128'h50000001_50000002_50000003_50000004;
        else if (a == 32'h0) return 128'h0;
        else return {a, ~a, a ^ 32'h0F0F0F0F, a + 32'd1};
    endfunction

    function automatic vec_t mk(input logic pb, input logic [3:0] m0, input logic [31:0] a0,
                                input logic [3:0] m1, input logic [31:0] a1, input logic [1:0] busy,
                                input logic [3:0] msg, input logic [31:0] addr,
                                input logic [1:0] dest, input logic l);
        vec_t v;
        v.pb = pb; v.m0 = m0; v.a0 = a0; v.m1 = m1; v.a1 = a1; v.busy = busy;
        v.msg = msg; v.addr = addr; v.data = line(addr); v.dest = dest; v.lg = l;
        return v;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] m0, input logic [31:0] a0,
                         input logic [3:0] m1, input logic [31:0] a1, input logic pb);
        r0_msg = m0; r0_addr = a0; r0_data = line(a0);
        r1_msg = m1; r1_addr = a1; r1_data = line(a1);
        pkt_busy = pb;
    endtask

    initial begin
        int i0, i1, w;
        logic [31:0] ea;

        r0_dest = 2'd1;
        r1_dest = 2'd2;
        reset   = 1'b0;
        drive(4'h1, 32'h0000_0100, 4'h0, 32'h0, 1'b0);

        vt[0]  = mk(1'b0, 4'h0, 32'h0,       4'h1, 32'h1000, 2'b01, 4'h1, 32'h1000,    2'd2, 1'b1);
        vt[1]  = mk(1'b0, 4'h0, 32'h0,       4'h0, 32'h0,    2'b11, 4'h0, 32'h0,       2'd0, 1'b1);
        vt[2]  = mk(1'b0, 4'h2, 32'h2000,    4'h3, 32'h3000, 2'b10, 4'h2, 32'h2000,    2'd1, 1'b0);
        vt[3]  = mk(1'b0, 4'h0, 32'h0,       4'h3, 32'h3000, 2'b01, 4'h3, 32'h3000,    2'd2, 1'b1);
        vt[4]  = mk(1'b0, 4'h0, 32'h0,       4'h0, 32'h0,    2'b11, 4'h0, 32'h0,       2'd0, 1'b1);
        vt[5]  = mk(1'b0, 4'h4, 32'h20000,   4'h0, 32'h0,    2'b10, 4'h4, 32'h20000,   2'd1, 1'b0);
        for (int k = 6; k <= 10; k++)
            vt[k] = mk(1'b1, 4'h0, 32'h0,    4'h2, 32'h4000, 2'b11, 4'h4, 32'h20000,   2'd1, 1'b0);
        vt[11] = mk(1'b0, 4'h0, 32'h0,       4'h2, 32'h4000, 2'b01, 4'h2, 32'h4000,    2'd2, 1'b1);
        vt[12] = mk(1'b1, 4'h0, 32'h0,       4'h0, 32'h0,    2'b11, 4'h2, 32'h4000,    2'd2, 1'b1);
        vt[13] = mk(1'b0, 4'h0, 32'h0,       4'h0, 32'h0,    2'b11, 4'h0, 32'h0,       2'd0, 1'b1);
        vt[14] = mk(1'b1, 4'h1, 32'h5000,    4'h0, 32'h0,    2'b10, 4'h1, 32'h5000,    2'd1, 1'b0);
        vt[15] = mk(1'b0, 4'h0, 32'h0,       4'h0, 32'h0,    2'b11, 4'h0, 32'h0,       2'd0, 1'b0);

        // Reset state, with a requester already presenting
        #12;
        check("reset busy", {busy1, busy0}, 2'b11);
        check("reset pkt", {p_msg, p_addr, p_data, p_dest}, '0);
        check("reset lg", lg, 1'b0);
        check("reset counters", {sent0, sent1}, 32'h0);

        @(negedge clock);
        drive(4'h0, 32'h0, 4'h0, 32'h0, 1'b0);
        reset = 1'b1;
        @(negedge clock);

        for (int i = 0; i < 16; i++) begin
            drive(vt[i].m0, vt[i].a0, vt[i].m1, vt[i].a1, vt[i].pb);
            #1;
            check($sformatf("vec%0d busy", i), {busy1, busy0}, vt[i].busy);
            @(posedge clock);
            #1;
            check($sformatf("vec%0d pkt", i), {p_msg, p_addr, p_data, p_dest},
                  {vt[i].msg, vt[i].addr, vt[i].data, vt[i].dest});
            check($sformatf("vec%0d last_grant", i), lg, vt[i].lg);
            if (i == 0) check("single req1_sent", sent1, 16'd1);
            @(negedge clock);
        end
        check("table req0_sent", sent0, 16'd3);
        check("table req1_sent", sent1, 16'd3);

        // Reset while a message is held under back-pressure
        drive(4'h6, 32'h6000, 4'h0, 32'h0, 1'b0);
        @(posedge clock);
        #1;
        check("pre-reset loaded", p_msg, 4'h6);
        @(negedge clock);
        drive(4'h0, 32'h0, 4'h7, 32'h7000, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        check("async reset pkt_msg", p_msg, 4'h0);
        check("async reset counters", {sent0, sent1}, 32'h0);
        check("async reset busy", {busy1, busy0}, 2'b11);
        @(negedge clock);
        reset = 1'b1;

        // Continuous contention starting with a tie right after reset
        i0 = 0;
        i1 = 0;
        for (int c = 0; c < 12; c++) begin
            drive((i0 < 6) ? 4'h5 : 4'h0, 32'h2000 + 32'(i0 * 16),
                  (i1 < 6) ? 4'h6 : 4'h0, 32'h3000 + 32'(i1 * 16), 1'b0);
            w = c % 2;
            #1;
            check($sformatf("rr%0d busy", c), {busy1, busy0}, (w == 0) ? 2'b10 : 2'b01);
            @(posedge clock);
            #1;
            ea = (w == 0) ? 32'h2000 + 32'(i0 * 16) : 32'h3000 + 32'(i1 * 16);
            check($sformatf("rr%0d pkt", c), {p_msg, p_addr, p_data},
                  {(w == 0) ? 4'h5 : 4'h6, ea, line(ea)});
            check($sformatf("rr%0d last_grant", c), lg, w[0]);
            if (w == 0) i0++; else i1++;
            if (c == 1) check("tie counters", {sent0, sent1}, {16'd1, 16'd1});
            @(negedge clock);
        end
        check("rr req0_sent", sent0, 16'd6);
        check("rr req1_sent", sent1, 16'd6);

        // Counter wrap on the narrow-counter instance
        drive(4'h0, 32'h0, 4'h0, 32'h0, 1'b0);
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        for (int k = 0; k < 17; k++) begin
            drive(4'h1, 32'h8000 + 32'(k), 4'h0, 32'h0, 1'b0);
            @(posedge clock);
            if (k != 16) @(negedge clock);
        end
        #1;
        check("wrap narrow req0_sent", w_sent0, 4'd1);
        check("wrap narrow req1_sent", w_sent1, 4'd0);
        check("wrap wide req0_sent", sent0, 16'd17);
        check("wrap narrow pkt", {w_msg, w_addr, w_data, w_dest, w_lg},
              {4'h1, 32'h8010, line(32'h8010), 2'd1, 1'b0});
        check("wrap narrow busy", {w_busy1, w_busy0}, 2'b10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
